// File: rtl/regfile_scan_ctrl.sv
// Runs the CPU for a programmed number of cycles, then borrows regfile read
// port A to stream every register out over valid/ready and count mismatches.
module regfile_scan_ctrl #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CYC_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [CYC_W-1:0]    num_cycles,
    input  logic [ADDR_W-1:0]   cpu_rs1,
    output logic [ADDR_W-1:0]   rf_readRegA,
    input  logic [DATA_W-1:0]   rf_dataA,
    output logic                cpu_run,
    output logic                scan_active,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_idx,
    output logic [DATA_W-1:0]   out_data,
    input  logic [DATA_W-1:0]   exp_data,
    output logic [ADDR_W:0]     mismatch_cnt,
    output logic [CYC_W-1:0]    cycle_count,
    output logic                done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [CYC_W-1:0]  CYC_MAX  = {CYC_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CYC_W-1:0]   limit;
    logic               hs_c;
    logic               miss_c;

    // Port A belongs to the scanner only while scan_active is set
    assign rf_readRegA = scan_active ? out_idx : cpu_rs1;

    assign hs_c   = out_valid && out_ready;
    assign miss_c = (out_data != exp_data);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            limit        <= '0;
            cpu_run      <= 1'b0;
            scan_active  <= 1'b0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            out_idx      <= '0;
            out_data     <= '0;
            mismatch_cnt <= '0;
            cycle_count  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        limit        <= num_cycles;
                        cycle_count  <= '0;
                        mismatch_cnt <= '0;
                        out_idx      <= '0;
                        done         <= 1'b0;
                        if (num_cycles == '0) begin
                            state       <= S_SETTLE;
                            scan_active <= 1'b1;
                        end else begin
                            state   <= S_RUN;
                            cpu_run <= 1'b1;
                        end
                    end
                end

                // cpu_run stays high for exactly limit cycles
                S_RUN: begin
                    if (cycle_count != CYC_MAX) begin
                        cycle_count <= cycle_count + CYC_W'(1);
                    end
                    if (cycle_count == limit - CYC_W'(1)) begin
                        state       <= S_SETTLE;
                        cpu_run     <= 1'b0;
                        scan_active <= 1'b1;
                    end
                end

                // Port A has shown out_idx for a full cycle; capture its data
                S_SETTLE: begin
                    out_data  <= rf_dataA;
                    out_valid <= 1'b1;
                    state     <= S_SCAN;
                end

                S_SCAN: begin
                    if (hs_c) begin
                        out_valid <= 1'b0;
                        if (miss_c) begin
                            mismatch_cnt <= mismatch_cnt + (ADDR_W + 1)'(1);
                        end
                        if (out_idx == LAST_IDX) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            scan_active <= 1'b0;
                        end else begin
                            out_idx <= out_idx + ADDR_W'(1);
                            state   <= S_SETTLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Bench for regfile_scan_ctrl: table-driven scan runs plus randomized runs,
// all checked against a transaction-level model of the run and dump.
module tb_regfile_scan_ctrl;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CYC_W    = 32;

    logic                clock;
    logic                reset;
    logic                start;
    logic [CYC_W-1:0]    num_cycles;
    logic [ADDR_W-1:0]   cpu_rs1;
    logic [ADDR_W-1:0]   rf_readRegA;
    logic [DATA_W-1:0]   rf_dataA;
    logic                cpu_run;
    logic                scan_active;
    logic                out_valid;
    logic                out_ready;
    logic [ADDR_W-1:0]   out_idx;
    logic [DATA_W-1:0]   out_data;
    logic [DATA_W-1:0]   exp_data;
    logic [ADDR_W:0]     mismatch_cnt;
    logic [CYC_W-1:0]    cycle_count;
    logic                done;

    logic [DATA_W-1:0]   regs [NUM_REGS];

    int checks   = 0;
    int failures = 0;

    regfile_scan_ctrl #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .cpu_rs1(cpu_rs1), .rf_readRegA(rf_readRegA), .rf_dataA(rf_dataA),
        .cpu_run(cpu_run), .scan_active(scan_active), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
        .exp_data(exp_data), .mismatch_cnt(mismatch_cnt),
        .cycle_count(cycle_count), .done(done)
    );

    // Behavioural regfile with a combinational read port
    assign rf_dataA = regs[rf_readRegA];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] n;
        int          stall_idx;
        int          stall_len;
        logic [31:0] bad;
        bit          poke;
        int          exp_mm;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One full run + dump; expectations derive from the run length, the
    // regfile contents and the set of deliberately wrong expected values.
    task automatic do_run(input logic [31:0] n, input int stall_idx, input int stall_len,
                          input logic [31:0] bad, input bit rnd_ready, input bit poke,
                          input int exp_mm, input int exp_cyc);
        int run_cnt;
        int cyc;
        int k;
        int stalled;
        for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = $urandom;
        num_cycles = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        num_cycles = $urandom_range(1, 3);
        chk("done_cleared_on_start", 64'(done), 64'd0);
        chk("mismatch_cleared_on_start", 64'(mismatch_cnt), 64'd0);

        run_cnt = 0;
        while (cpu_run && run_cnt < 1000) begin
            run_cnt++;
            start   = (poke && run_cnt == 2);
            cpu_rs1 = ADDR_W'($urandom);
            tick();
        end
        start = 1'b0;
        chk("run_cycles", 64'(run_cnt), 64'(n));
        chk("cycle_count", 64'(cycle_count), 64'(n));
        chk("settle_scan_active", 64'(scan_active), 64'd1);
        chk("settle_no_valid", 64'(out_valid), 64'd0);

        k = 0; cyc = 0; stalled = 0;
        while (!done && cyc < 2000) begin
            if (out_valid) begin
                exp_data = regs[out_idx] ^ DATA_W'(bad[out_idx]);
                if (int'(out_idx) == stall_idx && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                    chk("stall_hold_idx", 64'(out_idx), 64'(k));
                    chk("stall_hold_data", 64'(out_data), 64'(regs[k]));
                end else begin
                    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_ready) begin
                    chk("beat_idx", 64'(out_idx), 64'(k));
                    chk("beat_data", 64'(out_data), 64'(regs[k]));
                    k++;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            if (cyc == 1) chk("first_valid", 64'(out_valid), 64'd1);
            start   = (poke && k == 5);
            cpu_rs1 = ADDR_W'($urandom);
            tick();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk("scan_done", 64'(done), 64'd1);
        chk("beat_count", 64'(k), 64'(NUM_REGS));
        if (exp_cyc >= 0) chk("scan_cycles", 64'(cyc), 64'(exp_cyc));
        chk("mismatch_cnt", 64'(mismatch_cnt), 64'(exp_mm));
        chk("done_scan_active", 64'(scan_active), 64'd0);
        chk("done_cpu_run", 64'(cpu_run), 64'd0);
        chk("done_out_valid", 64'(out_valid), 64'd0);
        chk("done_cycle_count", 64'(cycle_count), 64'(n));
        cpu_rs1 = ADDR_W'($urandom);
        #1;
        chk("done_mux_cpu", 64'(rf_readRegA), 64'(cpu_rs1));
        tick();
        chk("done_held", 64'(done), 64'd1);
    endtask

    initial begin
        int g;
        logic [31:0] rbad;
        reset = 1'b1; start = 1'b0; num_cycles = '0; cpu_rs1 = 5'd9;
        out_ready = 1'b0; exp_data = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = $urandom;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_cpu_run", 64'(cpu_run), 64'd0);
        chk("rst_scan_active", 64'(scan_active), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_mismatch", 64'(mismatch_cnt), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        chk("rst_mux_cpu", 64'(rf_readRegA), 64'd9);

        vecs[0] = '{n: 5, stall_idx: -1, stall_len: 0, bad: 32'h0,          poke: 1'b0, exp_mm: 0,  exp_cyc: 64};
        vecs[1] = '{n: 0, stall_idx: -1, stall_len: 0, bad: 32'h0,          poke: 1'b0, exp_mm: 0,  exp_cyc: 64};
        vecs[2] = '{n: 1, stall_idx: 7,  stall_len: 3, bad: 32'h0,          poke: 1'b0, exp_mm: 0,  exp_cyc: 67};
        vecs[3] = '{n: 3, stall_idx: -1, stall_len: 0, bad: 32'h8000_0008,  poke: 1'b1, exp_mm: 2,  exp_cyc: 64};
        vecs[4] = '{n: 2, stall_idx: 0,  stall_len: 2, bad: 32'h0000_0001,  poke: 1'b0, exp_mm: 1,  exp_cyc: 66};
        vecs[5] = '{n: 6, stall_idx: 31, stall_len: 1, bad: 32'hFFFF_FFFF,  poke: 1'b1, exp_mm: 32, exp_cyc: 65};

        for (int v = 0; v < 6; v++) begin
            do_run(vecs[v].n, vecs[v].stall_idx, vecs[v].stall_len, vecs[v].bad,
                   1'b0, vecs[v].poke, vecs[v].exp_mm, vecs[v].exp_cyc);
        end

        // Reset while the beat for register 12 is pending
        num_cycles = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        g = 0;
        while (!(out_valid && out_idx == 5'd12) && g < 200) begin
            out_ready = 1'b1;
            tick();
            g++;
        end
        out_ready = 1'b0;
        chk("reached_idx12", 64'(out_idx), 64'd12);
        chk("idx12_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_scan_active", 64'(scan_active), 64'd0);
        chk("mid_rst_mux_cpu", 64'(rf_readRegA), 64'(cpu_rs1));
        chk("mid_rst_out_idx", 64'(out_idx), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        tick(); tick();
        chk("idle_no_valid", 64'(out_valid), 64'd0);
        chk("idle_no_run", 64'(cpu_run), 64'd0);
        do_run(32'd4, -1, 0, 32'h0000_1000, 1'b0, 1'b0, 1, 64);

        // Randomized runs with random back-pressure and random wrong expectations
        for (int r = 0; r < 6; r++) begin
            rbad = $urandom & $urandom;
            do_run(32'($urandom_range(0, 20)), -1, 0, rbad, 1'b1,
                   1'($urandom_range(0, 1)), $countones(rbad), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
